// File: rtl/noc_credit_sender.sv
// Credit-based NoC flit sender: 2-entry input FIFO, credit counter against the
// downstream router buffer, and a packet FSM that pins the head destination.
module noc_credit_sender #(
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CW                = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLIT_WIDTH-1:0] in_data,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_is_tail,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [CW-1:0]         credit_count,
  output logic                  pkt_active,
  output logic                  err_credit_overflow
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                state;
  state_t                state_next;
  logic [FLIT_WIDTH-1:0] fifo_data [2];
  logic [DEST_WIDTH-1:0] fifo_dest [2];
  logic [1:0]            fifo_tail;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  push;
  logic                  pop;
  logic [DEST_WIDTH-1:0] head_dest;
  logic [CW-1:0]         credit_next;
  logic                  overflow_set;

  // Upstream handshake: a flit moves on any rising edge where in_valid and
  // in_ready are both high; in_ready depends only on FIFO room and reset,
  // never on in_valid, and the sender must hold its flit until it moves.
  assign in_ready = ~rst & (occ != 2'd2);
  assign push     = in_valid & in_ready;
  // A credit arriving this cycle is not usable until it is in the counter.
  assign pop      = (occ != 2'd0) & (credit_count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= in_data;
      fifo_dest[wr_ptr] <= in_dest;
      fifo_tail[wr_ptr] <= in_is_tail;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  always_comb begin
    credit_next  = credit_count;
    overflow_set = 1'b0;
    if (pop && !credit_in) begin
      credit_next = credit_count - 1'b1;
    end else if (!pop && credit_in) begin
      if (credit_count == CW'(FLIT_BUFFER_DEPTH)) overflow_set = 1'b1;
      else                                         credit_next  = credit_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_count        <= CW'(FLIT_BUFFER_DEPTH);
      err_credit_overflow <= 1'b0;
    end else begin
      credit_count <= credit_next;
      if (overflow_set) err_credit_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (pop) state_next = fifo_tail[rd_ptr] ? IDLE : IN_PKT;
  end

  assign pkt_active = (state == IN_PKT);

  // Body and tail flits inherit the destination latched from their head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
      head_dest   <= '0;
    end else begin
      send_out <= pop;
      if (pop) begin
        data_out    <= fifo_data[rd_ptr];
        is_tail_out <= fifo_tail[rd_ptr];
        dest_out    <= (state == IDLE) ? fifo_dest[rd_ptr] : head_dest;
        if (state == IDLE) head_dest <= fifo_dest[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_noc_credit_sender.sv
// Bench for noc_credit_sender: queue-based behavioural model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_noc_credit_sender;

  localparam int FW    = 64;
  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_data;
  logic [DW-1:0] in_dest;
  logic          in_is_tail;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [CW-1:0] credit_count;
  logic          pkt_active;
  logic          err_credit_overflow;

  noc_credit_sender #(
    .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_is_tail(in_is_tail),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .credit_count(credit_count),
    .pkt_active(pkt_active), .err_credit_overflow(err_credit_overflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [FW-1:0] d;
    logic [DW-1:0] dst;
    logic          t;
  } flit_t;

  flit_t         mq[$];
  int            m_credits = DEPTH;
  bit            m_in_pkt  = 0;
  logic [DW-1:0] m_head    = '0;
  bit            m_err     = 0;
  bit            m_send    = 0;
  logic [FW-1:0] m_data    = '0;
  logic [DW-1:0] m_dest    = '0;
  bit            m_tail    = 0;
  bit            m_room;
  bit            m_go;
  flit_t         m_f;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_credits = DEPTH;
      m_in_pkt  = 0;
      m_head    = '0;
      m_err     = 0;
      m_send    = 0;
      m_data    = '0;
      m_dest    = '0;
      m_tail    = 0;
    end else begin
      m_room = (mq.size() < 2);
      m_go   = (mq.size() != 0) && (m_credits != 0);
      m_send = m_go;
      if (m_go) begin
        m_f    = mq.pop_front();
        m_data = m_f.d;
        m_tail = m_f.t;
        if (!m_in_pkt) m_head = m_f.dst;
        m_dest   = m_head;
        m_in_pkt = !m_f.t;
      end
      m_credits = m_credits - (m_go ? 1 : 0) + (credit_in ? 1 : 0);
      if (m_credits > DEPTH) begin
        m_credits = DEPTH;
        m_err     = 1;
      end
      if (in_valid && m_room) mq.push_back('{in_data, in_dest, in_is_tail});
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    check("send_out",     64'(send_out),            64'(m_send));
    check("data_out",     64'(data_out),            64'(m_data));
    check("dest_out",     64'(dest_out),            64'(m_dest));
    check("is_tail_out",  64'(is_tail_out),         64'(m_tail));
    check("credit_count", 64'(credit_count),        64'(m_credits));
    check("pkt_active",   64'(pkt_active),          64'(m_in_pkt));
    check("err_overflow", 64'(err_credit_overflow), 64'(m_err));
    check("in_ready",     64'(in_ready),            64'(!rst && (mq.size() < 2)));
  end

  // ---------------- send monitor ----------------
  int            sends_seen = 0;
  logic [FW-1:0] sent_data[$];
  logic [DW-1:0] sent_dest[$];
  logic          sent_act[$];

  always @(negedge clk) begin
    if (send_out) begin
      sends_seen++;
      sent_data.push_back(data_out);
      sent_dest.push_back(dest_out);
      sent_act.push_back(pkt_active);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic t,
                      input int bound, output bit acc);
    bit rdy;
    acc        = 0;
    in_valid   = 1'b1;
    in_data    = d;
    in_dest    = dst;
    in_is_tail = t;
    for (int c = 0; c < bound; c++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = 1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic push_ok(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic t);
    bit acc;
    push(d, dst, t, 20, acc);
    check("push_accept", 64'(acc), 64'd1);
  endtask

  task automatic credit_pulse();
    credit_in = 1'b1;
    @(posedge clk);
    #1;
    credit_in = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  int accepted;
  int base;
  int s0;
  bit acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0;
    in_is_tail = 1'b0; credit_in = 1'b0;
    idle(3);
    sample();
    check("rst_in_ready",   64'(in_ready),            64'd0);
    check("rst_credits",    64'(credit_count),        64'd8);
    check("rst_send",       64'(send_out),            64'd0);
    check("rst_pkt_active", 64'(pkt_active),          64'd0);
    check("rst_err",        64'(err_credit_overflow), 64'd0);
    check("rst_data_out",   64'(data_out),            64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);
    idle(1);

    // Burst of 12 single-flit packets with no credit return.
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      push(64'hA000 + 64'(i), DW'(i), 1'b1, 5, acc);
      if (!acc) break;
      accepted++;
    end
    sample();
    check("burst_accepted", 64'(accepted),     64'd10);
    check("burst_sends",    64'(sends_seen),   64'd8);
    check("burst_credits",  64'(credit_count), 64'd0);
    check("burst_in_ready", 64'(in_ready),     64'd0);

    // Return 4 credits, then feed the two flits that were refused.
    for (int i = 0; i < 4; i++) begin
      credit_pulse();
      idle(2);
    end
    push_ok(64'hA000 + 64'd10, 4'd10, 1'b1);
    push_ok(64'hA000 + 64'd11, 4'd11, 1'b1);
    idle(3);
    sample();
    check("return_sends",   64'(sends_seen),   64'd12);
    check("return_credits", 64'(credit_count), 64'd0);
    for (int i = 0; i < 12; i++)
      check("order", sent_data[i], 64'hA000 + 64'(i));

    // Multi-flit packet keeps the head destination.
    for (int i = 0; i < 8; i++) credit_pulse();
    idle(1);
    base = sent_dest.size();
    push_ok(64'hB001, 4'h5, 1'b0);
    push_ok(64'hB002, 4'hA, 1'b0);
    push_ok(64'hB003, 4'hF, 1'b1);
    idle(3);
    sample();
    check("pkt_sends", 64'(sent_dest.size() - base), 64'd3);
    for (int j = 0; j < 3; j++)
      check("pkt_dest_hold", 64'(sent_dest[base + j]), 64'h5);
    check("pkt_act_head", 64'(sent_act[base]),     64'd1);
    check("pkt_act_body", 64'(sent_act[base + 1]), 64'd1);
    check("pkt_act_tail", 64'(sent_act[base + 2]), 64'd0);
    check("pkt_credits",  64'(credit_count),       64'd5);

    // Send and credit return in the same cycle at count 3.
    push_ok(64'hC001, 4'h1, 1'b1);
    push_ok(64'hC002, 4'h2, 1'b1);
    idle(2);
    sample();
    check("sim_pre_credits", 64'(credit_count), 64'd3);
    push_ok(64'hC003, 4'h3, 1'b1);
    credit_pulse();
    sample();
    check("sim_send",    64'(send_out),     64'd1);
    check("sim_credits", 64'(credit_count), 64'd3);

    // Credit arriving at count 0 does not send in the same cycle.
    push_ok(64'hC004, 4'h4, 1'b1);
    push_ok(64'hC005, 4'h5, 1'b1);
    push_ok(64'hC006, 4'h6, 1'b1);
    idle(3);
    sample();
    check("drain_credits", 64'(credit_count), 64'd0);
    push_ok(64'hC007, 4'h7, 1'b1);
    credit_pulse();
    sample();
    check("zero_credit_count", 64'(credit_count), 64'd1);
    check("zero_credit_send",  64'(send_out),     64'd0);
    idle(1);
    sample();
    check("late_send",         64'(send_out),     64'd1);
    check("late_send_data",    data_out,          64'hC007);
    check("late_send_credits", 64'(credit_count), 64'd0);

    // Overflow when idle at full credit.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    sample();
    check("ovf_pre_credits", 64'(credit_count),        64'd8);
    check("ovf_pre_err",     64'(err_credit_overflow), 64'd0);
    credit_pulse();
    sample();
    check("ovf_credits", 64'(credit_count),        64'd8);
    check("ovf_err",     64'(err_credit_overflow), 64'd1);
    idle(5);
    sample();
    check("ovf_sticky", 64'(err_credit_overflow), 64'd1);

    // Reset after the head is sent, with the body still buffered.
    push_ok(64'hD001, 4'h3, 1'b0);
    push_ok(64'hD002, 4'hC, 1'b0);
    rst = 1'b1;
    s0  = sends_seen;
    sample();
    check("midrst_pkt_active", 64'(pkt_active),          64'd0);
    check("midrst_credits",    64'(credit_count),        64'd8);
    check("midrst_in_ready",   64'(in_ready),            64'd0);
    check("midrst_err",        64'(err_credit_overflow), 64'd0);
    idle(2);
    rst = 1'b0;
    idle(3);
    sample();
    check("midrst_discard", 64'(sends_seen - s0), 64'd0);
    push_ok(64'hD003, 4'h7, 1'b0);
    idle(2);
    sample();
    check("new_head_dest", 64'(sent_dest[$]), 64'h7);
    check("new_head_act",  64'(sent_act[$]),  64'd1);
    push_ok(64'hD004, 4'h9, 1'b1);
    idle(2);
    sample();
    check("new_tail_dest", 64'(sent_dest[$]), 64'h7);
    check("new_tail_act",  64'(sent_act[$]),  64'd0);
    check("new_tail_data", sent_data[$],      64'hD004);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
